// File: rtl/chunked_add_sub_if.sv
// Purpose: bundles the start/operand request and the busy/done/result response of chunked_add_sub.
// Latency: none (wiring only).
// Backpressure: none; the requester watches busy, and start is ignored while busy is high.
interface chunked_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, c_out, ovf
    );
endinterface

// File: rtl/chunked_add_sub.sv
// Purpose: WIDTH-bit add/sub computed CHUNK bits per clock, with a registered carry rippling between chunks.
// Latency: done pulses NCHUNK cycles after start is sampled; one operation per NCHUNK+1 cycles.
// Backpressure: start is ignored while busy. Define CHUNKED_ADD_SUB_SAT_EN to saturate the result on signed overflow.
module chunked_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    chunked_add_sub_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Reject configurations where the chunks do not tile the operand exactly.
    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("chunked_add_sub: WIDTH must be a positive multiple of CHUNK");
    end

`ifdef CHUNKED_ADD_SUB_SAT_EN
    // Most negative two's-complement value. Its inverse is the most positive value.
    localparam logic [WIDTH-1:0] SAT_MIN = (WIDTH)'(1) << (WIDTH - 1);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q, ovf_d;

    // Datapath for the current chunk.
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic [CHUNK:0]    sum;
    logic [WIDTH-1:0]  acc_next;
    logic              last;
    logic              c_msb_in;
    logic              ovf_calc;
    logic [WIDTH-1:0]  result_calc;

    // Select the active chunk, add it with the rippled carry, and merge it into the accumulator.
    always_comb begin
        chunk_a  = '0;
        chunk_b  = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                chunk_a = op_a_q[k*CHUNK +: CHUNK];
                chunk_b = op_b_q[k*CHUNK +: CHUNK];
            end
        end

        sum = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};

        acc_next = acc_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDXW'(k)) begin
                acc_next[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
            end
        end

        last = (idx_q == IDXW'(NCHUNK - 1));

        // The sum bit is a ^ b ^ cin, so the carry into the MSB can be recovered from the top bits of the chunk.
        // This matters only on the last chunk, where the top bit is the operand MSB.
        c_msb_in    = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ sum[CHUNK-1];
        ovf_calc    = c_msb_in ^ sum[CHUNK];
        result_calc = acc_next;
`ifdef CHUNKED_ADD_SUB_SAT_EN
        if (ovf_calc) begin
            result_calc = op_a_q[WIDTH-1] ? SAT_MIN : ~SAT_MIN;
        end
`endif
    end

    // Next-state logic: capture operands in IDLE, process one chunk per RUN cycle, and publish on the last chunk.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1. The +1 enters as the initial carry.
                    op_a_d  = bus.a;
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = acc_next;
                carry_d = sum[CHUNK];
                idx_d   = idx_q + IDXW'(1);
                if (last) begin
                    idx_d    = '0;
                    result_d = result_calc;
                    c_out_d  = sum[CHUNK];
                    ovf_d    = ovf_calc;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset aborts any operation in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: doc/chunked_add_sub.md
Name: chunked_add_sub

Overview:
Parametrised multi-cycle adder/subtractor for the calculator datapath. It processes WIDTH-bit operands CHUNK bits per clock, rippling a registered carry between chunks. A start/busy/done handshake controls it. It reports carry-out and signed overflow, so one narrow adder slice can serve wide operands.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK
CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK, derived localparam; number of RUN cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only when not busy
sub  input  1  0 = a+b, 1 = a-b; captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result, c_out and ovf are updated this cycle
result  output  WIDTH  sum/difference; held until the next completion
c_out  output  1  carry out of the MSB (for sub: 1 = no borrow)
ovf  output  1  signed two's-complement overflow of the last operation

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, c_out=0, ovf=0; internal operand, carry and chunk-index registers cleared. Takes effect immediately, including mid-operation. The aborted operation produces no done.
- States: IDLE, RUN.
- IDLE with start=1 at edge E0:
  - latch a into opA;
  - latch b into opB, bitwise-inverted when sub=1;
  - carry <= sub;
  - idx <= 0;
  - go RUN; busy=1 from E0.
- RUN, edge i (i = 0..NCHUNK-1 counted from E0+1):
  - {carry, acc[idx*CHUNK +: CHUNK]} <= opA chunk + opB chunk + carry;
  - idx increments;
  - on the final chunk, also capture carry-into-MSB for the overflow computation.
- Completion, at edge E0+NCHUNK:
  - result <= acc, including the final chunk;
  - c_out <= final carry;
  - ovf <= carry-into-MSB XOR carry-out-of-MSB;
  - done=1 for exactly one cycle; busy=0; state=IDLE.
- Latency: done is high in the cycle after edge E0+NCHUNK, i.e. NCHUNK cycles after start is sampled. Throughput is one operation per NCHUNK+1 cycles. Back-to-back is allowed: start sampled on the edge that ends the done cycle is accepted.
- start while busy=1: ignored. a, b and sub may change freely during RUN without effect.
- result, c_out and ovf change only at completion or reset. They stay stable through later RUN phases.
- NCHUNK=1 (CHUNK=WIDTH): a single RUN edge; done arrives one cycle after start.
- Arithmetic is modulo 2^WIDTH; wrap-around is silent except for the c_out/ovf flags.

Optional Feature:
Macro CHUNKED_ADD_SUB_SAT_EN.
- Defined: when ovf would be 1, result is saturated instead of wrapped.
  - Saturates to 2^(WIDTH-1)-1 if the MSB of opA is 0.
  - Saturates to -2^(WIDTH-1) (MSB=1, rest 0) if the MSB of opA is 1.
  - ovf is still reported as 1; c_out is unchanged.
- Undefined: result always wraps; no saturation logic is present.

Test Plan:
All scenarios use WIDTH=16, CHUNK=4 unless noted.
1. a=0x1234, b=0x0FFF, sub=0, start pulse -> busy for 4 cycles; done pulses 4 cycles after start; result=0x2233, c_out=0, ovf=0.
2. a=0xFFFF, b=0x0001, sub=0 -> result=0x0000, c_out=1, ovf=0. Then a=0x0005, b=0x0007, sub=1 -> result=0xFFFE, c_out=0, ovf=0.
3. a=0x7FFF, b=0x0001, sub=0 -> ovf=1; result=0x8000 without the macro, 0x7FFF with CHUNKED_ADD_SUB_SAT_EN. Also a=0x8000, b=0x0001, sub=1 -> ovf=1; result=0x7FFF without the macro, 0x8000 with it.
4. start held high continuously, with a/b changing every cycle -> an operation is accepted only in IDLE, back-to-back every 5 cycles. Each result matches the operands present on its accepting edge. No done is lost or duplicated.
5. rst_n pulsed low 2 cycles into an operation -> busy, done, result, c_out and ovf go to 0 immediately, with no done for the aborted operation. The next start with a=0x00FF, b=0x0001 gives result=0x0100.
6. Parameter sweep WIDTH=8 with CHUNK=1, 8 and 16 with CHUNK=16 -> done latency equals NCHUNK cycles. Random operands match the reference a±b mod 2^WIDTH, plus the c_out and ovf flags.
